// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce and a one-clock key strobe.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEB_FRAMES   = 4,
  parameter int REPEAT_DELAY = 125,
  parameter int REPEAT_RATE  = 25
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] o_row,
  input  logic [3:0] i_col,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_held
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  localparam logic [31:0] DIV_LAST = 32'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_N    = 4'(DEB_FRAMES);

  logic [31:0] r_div;
  logic [1:0]  r_rowIdx;
  logic [3:0]  r_colMeta, r_colSync;
  logic [1:0]  r_frameCnt;
  logic [3:0]  r_lastKey;

  state_t      r_state, w_nextState;
  logic [3:0]  r_cand, w_nextCand;
  logic [3:0]  r_dcnt, w_nextDcnt;
  logic [3:0]  r_rcnt, w_nextRcnt;
  logic [3:0]  r_keyCode, w_nextCode;
  logic        r_keyValid, w_nextValid;
  logic        r_keyHeld, w_nextHeld;

  logic        w_tick, w_frameEnd;
  logic [3:0]  w_colAct;
  logic [2:0]  w_rowHits, w_sumCnt;
  logic [1:0]  w_rowCol, w_frameCntNext;
  logic [3:0]  w_lastKeyNext;
  logic        w_isNone, w_isKey;
  logic        w_accept;
  logic [3:0]  w_acceptKey;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_frameEnd = w_tick && (r_rowIdx == 2'd3);
  assign o_row      = ~(4'b0001 << r_rowIdx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_colMeta <= 4'hF;
      r_colSync <= 4'hF;
    end else begin
      r_div     <= w_tick ? '0 : r_div + 32'd1;
      r_colMeta <= i_col;
      r_colSync <= r_colMeta;
    end
  end

  // Only 0 / 1 / many matters, so the frame hit count saturates at 2.
  assign w_colAct  = ~r_colSync;
  assign w_rowHits = {2'b0, w_colAct[0]} + {2'b0, w_colAct[1]}
                   + {2'b0, w_colAct[2]} + {2'b0, w_colAct[3]};
  assign w_sumCnt  = {1'b0, r_frameCnt} + w_rowHits;
  assign w_frameCntNext = (w_sumCnt >= 3'd2) ? 2'd2 : w_sumCnt[1:0];

  always_comb begin
    w_rowCol = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (w_colAct[c]) w_rowCol = 2'(c);
    end
  end

  assign w_lastKeyNext = (w_rowHits != 3'd0) ? {r_rowIdx, w_rowCol} : r_lastKey;
  assign w_isNone      = (w_frameCntNext == 2'd0);
  assign w_isKey       = (w_frameCntNext == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rowIdx   <= '0;
      r_frameCnt <= '0;
      r_lastKey  <= '0;
    end else if (w_tick) begin
      r_rowIdx <= r_rowIdx + 2'd1;
      if (r_rowIdx == 2'd3) begin
        r_frameCnt <= '0;
        r_lastKey  <= '0;
      end else begin
        r_frameCnt <= w_frameCntNext;
        r_lastKey  <= w_lastKeyNext;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [15:0] REP_DELAY = 16'(REPEAT_DELAY);
  localparam logic [15:0] REP_RATE  = 16'(REPEAT_RATE);
  logic [15:0] r_repCnt, w_nextRep;
`endif

  always_comb begin
    w_nextState = r_state;
    w_nextCand  = r_cand;
    w_nextDcnt  = r_dcnt;
    w_nextRcnt  = r_rcnt;
    w_nextCode  = r_keyCode;
    w_nextValid = 1'b0;
    w_nextHeld  = r_keyHeld;
    w_accept    = 1'b0;
    w_acceptKey = r_cand;
`ifdef KEY_REPEAT_EN
    w_nextRep   = r_repCnt;
`endif
    if (w_frameEnd) begin
      case (r_state)
        IDLE: begin
          if (w_isKey) begin
            w_nextCand = w_lastKeyNext;
            w_nextDcnt = 4'd1;
            if (DEB_N == 4'd1) begin
              w_accept    = 1'b1;
              w_acceptKey = w_lastKeyNext;
            end else begin
              w_nextState = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!w_isKey) begin
            w_nextState = IDLE;
            w_nextDcnt  = 4'd0;
          end else if (w_lastKeyNext == r_cand) begin
            w_nextDcnt = r_dcnt + 4'd1;
            if (r_dcnt + 4'd1 == DEB_N) begin
              w_accept    = 1'b1;
              w_acceptKey = r_cand;
            end
          end else begin
            w_nextCand = w_lastKeyNext;
            w_nextDcnt = 4'd1;
          end
        end
        PRESSED: begin
          if (w_isNone) begin
            w_nextRcnt = r_rcnt + 4'd1;
            if (r_rcnt + 4'd1 == DEB_N) begin
              w_nextState = IDLE;
              w_nextHeld  = 1'b0;
              w_nextRcnt  = 4'd0;
              w_nextDcnt  = 4'd0;
            end
          end else begin
            w_nextRcnt = 4'd0;
          end
`ifdef KEY_REPEAT_EN
          // First repeat after REP_DELAY frames; later ones fold back to REP_DELAY.
          if (w_isNone) begin
            w_nextRep = '0;
          end else begin
            w_nextRep = r_repCnt + 16'd1;
            if (w_nextRep == REP_DELAY) begin
              w_nextValid = 1'b1;
            end else if (w_nextRep == REP_DELAY + REP_RATE) begin
              w_nextValid = 1'b1;
              w_nextRep   = REP_DELAY;
            end
          end
`endif
        end
        default: w_nextState = IDLE;
      endcase
      if (w_accept) begin
        w_nextState = PRESSED;
        w_nextCode  = w_acceptKey;
        w_nextValid = 1'b1;
        w_nextHeld  = 1'b1;
        w_nextRcnt  = 4'd0;
`ifdef KEY_REPEAT_EN
        w_nextRep   = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cand     <= '0;
      r_dcnt     <= '0;
      r_rcnt     <= '0;
      r_keyCode  <= '0;
      r_keyValid <= 1'b0;
      r_keyHeld  <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cand     <= w_nextCand;
      r_dcnt     <= w_nextDcnt;
      r_rcnt     <= w_nextRcnt;
      r_keyCode  <= w_nextCode;
      r_keyValid <= w_nextValid;
      r_keyHeld  <= w_nextHeld;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) r_repCnt <= '0;
    else     r_repCnt <= w_nextRep;
  end
`endif

  assign o_key_code  = r_keyCode;
  assign o_key_valid = r_keyValid;
  assign o_key_held  = r_keyHeld;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
4x4 matrix keypad scanner. It is the input-side counterpart of the multiplexed seven-segment display driver: it drives one active-low row at a time, reads the active-low columns, debounces over whole scan frames, and emits a 4-bit key code with a one-clock valid strobe. It feeds user key events (time set, mode select) into the counter/display top level.

Parameters:
SCAN_DIV, 50000, clk cycles per row slot (1 ms at 50 MHz); legal range >= 4
DEB_FRAMES, 4, consecutive identical frames required to accept a press or a release; legal range 1..15
REPEAT_DELAY, 125, frames held before the first auto-repeat (KEY_REPEAT_EN only)
REPEAT_RATE, 25, frames between auto-repeats (KEY_REPEAT_EN only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
o_row  output  4  row drive, active-low, exactly one bit low
i_col  input  4  column sense, active-low, pulled up externally
o_key_code  output  4  row*4 + col of the accepted key
o_key_valid  output  1  one-clk strobe per accepted press
o_key_held  output  1  high while an accepted key is held

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state is updated only on posedge clk.
- Reset values: o_row=4'b1110, o_key_code=0, o_key_valid=0, o_key_held=0, state=IDLE. Divider, row index, frame accumulators and counters are all 0.
- Divider: 32-bit counter from 0 to SCAN_DIV-1. tick=1 when the count equals SCAN_DIV-1; the count then wraps to 0.
- Row index r (0..3): advances on tick and wraps 3->0. o_row = ~(4'b0001 << r).
- i_col passes through a 2-flop synchronizer. On tick, the synchronized column value is sampled for the current row before r advances. SCAN_DIV>=4 guarantees settling.
- Frame accumulation over r=0..3:
  - count = number of active (low) column bits across all rows.
  - Record the row and column of the last active bit.
- Frame end is the tick at r=3. Frame result:
  - NONE if count=0.
  - KEY(k), k = row*4 + col, if count=1.
  - MULTI if count>=2.
- FSM, evaluated only at frame end:
  - IDLE:
    - KEY(k): cand=k, dcnt=1. Go to PRESSED if DEB_FRAMES=1, otherwise to DEBOUNCE.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - KEY(cand): dcnt++. When dcnt reaches DEB_FRAMES, go to PRESSED.
    - KEY(j) with j!=cand: cand=j, dcnt=1.
    - NONE or MULTI: go to IDLE.
  - Entry into PRESSED:
    - o_key_code=cand, o_key_valid=1 for exactly the clock after the frame-end tick, o_key_held=1, rcnt=0.
  - PRESSED:
    - NONE: rcnt++. When rcnt reaches DEB_FRAMES, go to IDLE and set o_key_held=0.
    - KEY (any key) or MULTI: rcnt=0 and stay in PRESSED. No new strobe; a second key cannot generate a press until the first is released.
- Latency: o_key_valid rises 1 clk after the frame-end tick of the DEB_FRAMES-th consecutive matching frame.
- o_key_code holds its value until the next accepted press.
- Reset mid-operation: outputs and state return to reset values at the next edge. No strobe is generated from a pre-reset partial debounce.

Optional Feature:
KEY_REPEAT_EN
- Defined: in PRESSED, count frames while not NONE.
  - After REPEAT_DELAY frames, pulse o_key_valid (same code).
  - Then pulse every REPEAT_RATE frames until release.
  - The repeat counter clears when a NONE frame occurs and on leaving PRESSED.
- Undefined: exactly one strobe per press. The REPEAT_* parameters are unused.

Test Plan:
All scenarios use SCAN_DIV=4 and DEB_FRAMES=3, giving a frame of 16 clks.
- Reset: assert rst, then release -> o_row=1110, all outputs 0; o_row=1101 after 4 clks, 1011 after 8, 0111 after 12, 1110 after 16.
- Clean press: model row2/col1 (i_col[1] low while o_row[2] low), held stable -> one o_key_valid pulse with o_key_code=9 one clk after the 3rd frame end, then o_key_held=1. Release -> o_key_held=0 after 3 NONE frames. Exactly 1 strobe in total.
- Bounce: key 9 present for 2 frames, absent 1, present 2, absent 1, repeated 4 times -> no strobe, o_key_held stays 0.
- Multi-press: keys 0 and 5 together for 10 frames -> no strobe. Then release key 5 (key 0 alone) -> strobe with code 0 after 3 frames.
- Reset mid-debounce: key 14 stable, rst pulsed for 1 clk during frame 2 -> no strobe from the aborted sequence and o_row=1110. After reset, the key is accepted 3 full frames later with code 14.
- KEY_REPEAT_EN defined, REPEAT_DELAY=4, REPEAT_RATE=2: key 3 held for 12 frames -> strobe at accept, then further strobes at frames 4, 6, 8, 10 after accept, all with code 3.
